fft8_input_reorder: RTL and testbench

Input reorder buffer for the 8-point radix-2 DIT FFT. It sits directly upstream of the first butterfly stage. It accepts one complex sample per cycle in natural order and collects each frame of 8 into a ping-pong buffer. It then emits the frame as four bit-reversed butterfly pairs, one pair per beat, on the (A, B) operand ports of stage 1.

---
 rtl/fft8_input_reorder.sv | 151 +++++++++++++++
 tb/tb_fft8_input_reorder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fft8_input_reorder.sv
// fft8_input_reorder
// Natural-order to bit-reversed-pair reorder buffer feeding stage 1 of an
// 8-point radix-2 DIT FFT. Samples are collected into one of two 8-entry
// flop banks (ping-pong). Each full bank is emitted as four (A, B)
// butterfly pairs, one pair per beat.
module fft8_input_reorder #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ar1,
  output logic [W-1:0] ai1,
  output logic [W-1:0] ar2,
  output logic [W-1:0] ai2,
  output logic         out_first,
  output logic         out_last
);

  localparam int EW = 2 * W;

  // 3-bit bit reversal used to map butterfly pair numbers to sample slots
  function automatic logic [2:0] bitrev3(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  // Operand A of pair k is sample bitrev3(2k)
  function automatic logic [2:0] pair_a_idx(input logic [1:0] k);
    return bitrev3({k, 1'b0});
  endfunction

  // Operand B of pair k is sample bitrev3(2k+1)
  function automatic logic [2:0] pair_b_idx(input logic [1:0] k);
    return bitrev3({k, 1'b1});
  endfunction

  // Storage and control state
  logic [EW-1:0] bank_q [2][8];
  logic [EW-1:0] bank_d [2][8];
  logic          wr_bank_q, wr_bank_d;
  logic [2:0]    wr_cnt_q,  wr_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    rd_cnt_q,  rd_cnt_d;
  logic [1:0]    full_q,    full_d;

  logic          wr_fire;
  logic          rd_fire;

  // Read-side operand views, kept signed for clarity of the datapath
  logic [EW-1:0]       entry_a;
  logic [EW-1:0]       entry_b;
  logic signed [W-1:0] a_re, a_im, b_re, b_im;

  // Handshake flags come straight from registered state only
  always_comb begin
    in_ready  = ~full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    wr_fire   = in_valid & in_ready;
    rd_fire   = out_valid & out_ready;
  end

  // Write side: capture sample into the fill bank, advance slot, close bank
  always_comb begin
    bank_d    = bank_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (wr_fire) begin
      bank_d[wr_bank_q][wr_cnt_q] = {in_re, in_im};
      wr_cnt_d                    = wr_cnt_q + 3'd1;
      if (wr_cnt_q == 3'd7) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  // Read side: advance pair counter, release drained bank
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 2'd1;
      if (rd_cnt_q == 2'd3) begin
        rd_bank_d = ~rd_bank_q;
      end
    end
  end

  // Bank occupancy: a completed fill sets, a completed drain clears; the two
  // always address different banks because a bank is never read before full
  always_comb begin
    full_d = full_q;
    if (wr_fire && (wr_cnt_q == 3'd7)) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (rd_fire && (rd_cnt_q == 2'd3)) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 2'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
    end
  end

  // Sample storage; cleared on reset so the idle outputs read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < 8; e++) begin
          bank_q[b][e] <= '0;
        end
      end
    end else begin
      bank_q <= bank_d;
    end
  end

  // Output mux: select the current pair from the read bank
  always_comb begin
    entry_a   = bank_q[rd_bank_q][pair_a_idx(rd_cnt_q)];
    entry_b   = bank_q[rd_bank_q][pair_b_idx(rd_cnt_q)];
    a_re      = entry_a[EW-1:W];
    a_im      = entry_a[W-1:0];
    b_re      = entry_b[EW-1:W];
    b_im      = entry_b[W-1:0];
    ar1       = a_re;
    ai1       = a_im;
    ar2       = b_re;
    ai2       = b_im;
    out_first = out_valid & (rd_cnt_q == 2'd0);
    out_last  = out_valid & (rd_cnt_q == 2'd3);
  end

endmodule

// File: tb/tb_fft8_input_reorder.sv
// Directed bench for fft8_input_reorder. Sample n of frame f carries
// re = 16*f + n + 1, im = -re; expected pairs are derived from that rule.
module tb_fft8_input_reorder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ar1, ai1, ar2, ai2;
  logic         out_first;
  logic         out_last;

  int n_tests = 0;
  int n_fail  = 0;
  int g = 0;   // samples accepted since last reset
  int b = 0;   // beats transferred since last reset

  fft8_input_reorder #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ar1       (ar1),
    .ai1       (ai1),
    .ar2       (ar2),
    .ai2       (ai2),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] samp(input int idx);
    return W'((idx / 8) * 16 + (idx % 8) + 1);
  endfunction

  // Expected {ar1, ai1, ar2, ai2} for global beat index bi
  function automatic logic [63:0] exp_word(input int bi);
    int k;
    int ai;
    logic [W-1:0] a, bb, na, nb;
    k  = bi % 4;
    ai = (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 1 : 3;
    a  = W'((bi / 4) * 16 + ai + 1);
    bb = W'((bi / 4) * 16 + ai + 5);
    na = -a;
    nb = -bb;
    return {a, na, bb, nb};
  endfunction

  function automatic logic [1:0] exp_flags(input int bi);
    return {((bi % 4) == 0), ((bi % 4) == 3)};
  endfunction

  task automatic drive_sample();
    logic [W-1:0] v;
    v     = samp(g);
    in_re = v;
    in_im = -v;
  endtask

  // One clock: score the beat being transferred, then advance the model
  task automatic step(input string tag);
    logic acc, xfer;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    if (xfer) begin
      check({tag, "_data"}, {ar1, ai1, ar2, ai2}, exp_word(b));
      check({tag, "_flags"}, {out_first, out_last}, exp_flags(b));
    end
    @(posedge clk);
    #1;
    if (acc)  g++;
    if (xfer) b++;
    drive_sample();
  endtask

  // Asynchronous reset away from the clock edge; outputs checked before any edge
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_flags"}, {out_first, out_last}, 0);
    check({tag, "_data"}, {ar1, ai1, ar2, ai2}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    g = 0;
    b = 0;
    drive_sample();
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_re     = '0;
    in_im     = '0;

    do_reset("rst_init");

    // Single frame, fill latency and four consecutive beats
    in_valid = 1'b1;
    for (int i = 0; i < 20 && g < 8; i++) begin
      check("fill_no_valid", out_valid, 0);
      step("single");
    end
    in_valid = 1'b0;
    check("fill_count", g, 8);
    check("fill_latency", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      check("single_consec", out_valid, 1);
      step("single");
    end
    check("single_beats", b, 4);
    check("single_idle", out_valid, 0);

    // Three back-to-back frames with a non-stalling consumer
    do_reset("rst_stream");
    in_valid = 1'b1;
    for (int i = 0; i < 40 && g < 24; i++) begin
      check("stream_in_ready", in_ready, 1);
      step("stream");
    end
    in_valid = 1'b0;
    check("stream_accepts", g, 24);
    for (int i = 0; i < 20 && b < 12; i++) step("stream");
    check("stream_beats", b, 12);

    // Backpressure: exactly 16 accepts, outputs frozen on pair 0
    do_reset("rst_bp");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step("bp");
      check("bp_in_ready", in_ready, (g < 16) ? 1 : 0);
      check("bp_out_valid", out_valid, (g >= 8) ? 1 : 0);
      if (out_valid) begin
        check("bp_frozen_data", {ar1, ai1, ar2, ai2}, exp_word(0));
        check("bp_frozen_flags", {out_first, out_last}, 2'b10);
      end
    end
    check("bp_accepts", g, 16);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step("bp_drain0");
    check("bp_frame0_beats", b, 4);
    check("bp_ready_back", in_ready, 1);
    for (int i = 0; i < 10 && b < 8; i++) step("bp_drain1");
    check("bp_frame1_beats", b, 8);
    check("bp_idle", out_valid, 0);

    // Reset mid-run with both banks holding data
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 12; i++) step("pre_rst");
    check("pre_rst_valid", out_valid, 1);
    do_reset("rst_midrun");
    out_ready = 1'b1;

    // Partial frame discarded by reset
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step("partial");
    check("partial_count", g, 5);
    do_reset("rst_partial");
    in_valid = 1'b1;
    for (int i = 0; i < 20 && g < 8; i++) step("clean");
    in_valid = 1'b0;
    for (int i = 0; i < 10 && b < 4; i++) step("clean");
    check("clean_beats", b, 4);
    check("clean_idle", out_valid, 0);

    // Mid-drain stall on beat 2
    do_reset("rst_stall");
    in_valid = 1'b1;
    for (int i = 0; i < 20 && g < 8; i++) step("stall_fill");
    in_valid = 1'b0;
    for (int i = 0; i < 10 && b < 2; i++) step("stall_pre");
    check("stall_pre_beats", b, 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold_data", {ar1, ai1, ar2, ai2}, {16'd2, 16'hFFFE, 16'd6, 16'hFFFA});
      check("stall_hold_flags", {out_first, out_last}, 2'b00);
      step("stall_hold");
    end
    check("stall_no_xfer", b, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && b < 4; i++) step("stall_post");
    check("stall_post_beats", b, 4);
    step("stall_tail");
    check("stall_no_dup", out_valid, 0);
    check("stall_beat_total", b, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
